// File: rtl/ddp_mm_pkg.sv
// Shared sizing, command encoding and stored-entry layout for the matching-memory RAM.
package ddp_mm_pkg;
    localparam int DEPTH  = 64;
    localparam int ADDR_W = 6;
    localparam int DATA_W = 16;
    localparam int HDR_W  = 16;

    typedef enum logic [1:0] {
        CMD_BYPASS  = 2'd0,
        CMD_WRITE   = 2'd1,
        CMD_FIRE    = 2'd2,
        CMD_ILLEGAL = 2'd3
    } cmd_e;

    typedef struct packed {
        logic              lr;
        logic [DATA_W-1:0] data;
    } entry_t;

    localparam int ENTRY_W = $bits(entry_t);

    // Non-matching packets ignore WR_E/DEL; a matching packet needs exactly one of them.
    function automatic cmd_e decode_cmd(input logic match, input logic wr_e, input logic del);
        if (!match)       return CMD_BYPASS;
        if (wr_e == del)  return CMD_ILLEGAL;
        return wr_e ? CMD_WRITE : CMD_FIRE;
    endfunction
endpackage

// File: rtl/mmram_join_if.sv
// Packet/command handshake bundle between the CAM allocator, the RAM join stage and downstream.
interface mmram_join_if;
    import ddp_mm_pkg::*;

    logic              IN_REQ;
    logic              IN_ACK;
    logic              MATCH;
    logic              WR_E;
    logic              DEL;
    logic [ADDR_W-1:0] ADDR;
    logic              IN_LR;
    logic [HDR_W-1:0]  IN_HDR;
    logic [DATA_W-1:0] IN_DATA;
    logic              OUT_REQ;
    logic              OUT_ACK;
    logic [HDR_W-1:0]  OUT_HDR;
    logic [DATA_W-1:0] OUT_LD;
    logic [DATA_W-1:0] OUT_RD;
    logic              OUT_SINGLE;
    logic [DEPTH-1:0]  CLR_EN;
    logic [ADDR_W:0]   OCC;
    logic              ERR;

    modport slave (
        input  IN_REQ, MATCH, WR_E, DEL, ADDR, IN_LR, IN_HDR, IN_DATA, OUT_ACK,
        output IN_ACK, OUT_REQ, OUT_HDR, OUT_LD, OUT_RD, OUT_SINGLE, CLR_EN, OCC, ERR
    );

    modport master (
        output IN_REQ, MATCH, WR_E, DEL, ADDR, IN_LR, IN_HDR, IN_DATA, OUT_ACK,
        input  IN_ACK, OUT_REQ, OUT_HDR, OUT_LD, OUT_RD, OUT_SINGLE, CLR_EN, OCC, ERR
    );
endinterface

// File: rtl/mmram_sp_sync.sv
// One-write/one-read synchronous RAM with registered read; contents survive reset.
module mmram_sp_sync #(
    parameter int DEPTH = 64,
    parameter int AW    = 6,
    parameter int W     = 17
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [W-1:0]  rdata
);
    logic [W-1:0] mem [DEPTH];

    // rdata only moves on a read so a stalled consumer keeps its operand.
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        if (re) rdata <= mem[raddr];
    end
endmodule

// File: rtl/mmram_join.sv
// Matching-memory RAM join: stores waiting operands, joins fired pairs, bypasses singles.
module mmram_join
    import ddp_mm_pkg::*;
(
    input logic         CP,
    input logic         MR,
    mmram_join_if.slave bus
);
    localparam logic [DEPTH-1:0] CLR_ONE = DEPTH'(1);

    cmd_e              cmd;
    logic              in_ack, acc, s1_adv;
    logic              wr_acc, fire_acc, byp_acc, ill_acc;

    logic              s1_v, s1_fire, s1_lr;
    logic [HDR_W-1:0]  s1_hdr;
    logic [DATA_W-1:0] s1_data;
    logic [ENTRY_W-1:0] rd_raw;
    entry_t            rd_entry;

    logic              s2_v, out_single;
    logic [HDR_W-1:0]  out_hdr;
    logic [DATA_W-1:0] out_ld, out_rd;

    logic [DEPTH-1:0]  vld, clr_en;
    logic [ADDR_W:0]   occ;
    logic              err;

    assign cmd      = decode_cmd(bus.MATCH, bus.WR_E, bus.DEL);
    assign s1_adv   = !s2_v || bus.OUT_ACK;
    assign in_ack   = !MR && (!s1_v || s1_adv);
    assign acc      = bus.IN_REQ && in_ack;
    assign wr_acc   = acc && (cmd == CMD_WRITE);
    assign fire_acc = acc && (cmd == CMD_FIRE);
    assign byp_acc  = acc && (cmd == CMD_BYPASS);
    assign ill_acc  = acc && (cmd == CMD_ILLEGAL);
    assign rd_entry = rd_raw;

    mmram_sp_sync #(.DEPTH(DEPTH), .AW(ADDR_W), .W(ENTRY_W)) u_ram (
        .clk   (CP),
        .we    (wr_acc),
        .waddr (bus.ADDR),
        .wdata ({bus.IN_LR, bus.IN_DATA}),
        .re    (fire_acc),
        .raddr (bus.ADDR),
        .rdata (rd_raw)
    );

    // Entry bookkeeping; WRITE and FIRE are mutually exclusive in one cycle.
    always_ff @(posedge CP) begin
        if (MR) begin
            vld    <= '0;
            occ    <= '0;
            err    <= 1'b0;
            clr_en <= '0;
        end else begin
            clr_en <= fire_acc ? (CLR_ONE << bus.ADDR) : '0;
            if (wr_acc) begin
                vld[bus.ADDR] <= 1'b1;
                if (vld[bus.ADDR]) err <= 1'b1;
                else               occ <= occ + 1'b1;
            end
            if (fire_acc) begin
                vld[bus.ADDR] <= 1'b0;
                if (!vld[bus.ADDR]) err <= 1'b1;
                else                occ <= occ - 1'b1;
            end
            if (ill_acc) err <= 1'b1;
            // Partner on the same side means the CAM matched two left or two right operands.
            if (s1_v && s1_fire && (rd_entry.lr == s1_lr)) err <= 1'b1;
        end
    end

    always_ff @(posedge CP) begin
        if (MR)          s1_v <= 1'b0;
        else if (in_ack) s1_v <= fire_acc || byp_acc;
    end

    always_ff @(posedge CP) begin
        if (in_ack) begin
            s1_fire <= fire_acc;
            s1_lr   <= bus.IN_LR;
            s1_hdr  <= bus.IN_HDR;
            s1_data <= bus.IN_DATA;
        end
    end

    always_ff @(posedge CP) begin
        if (MR) begin
            s2_v       <= 1'b0;
            out_hdr    <= '0;
            out_ld     <= '0;
            out_rd     <= '0;
            out_single <= 1'b0;
        end else if (s1_adv) begin
            s2_v <= s1_v;
            if (s1_v) begin
                out_hdr    <= s1_hdr;
                out_single <= !s1_fire;
                if (!s1_fire) begin
                    out_ld <= s1_data;
                    out_rd <= '0;
                end else if (s1_lr) begin
                    out_ld <= rd_entry.data;
                    out_rd <= s1_data;
                end else begin
                    out_ld <= s1_data;
                    out_rd <= rd_entry.data;
                end
            end
        end
    end

    assign bus.IN_ACK     = in_ack;
    assign bus.OUT_REQ    = s2_v;
    assign bus.OUT_HDR    = out_hdr;
    assign bus.OUT_LD     = out_ld;
    assign bus.OUT_RD     = out_rd;
    assign bus.OUT_SINGLE = out_single;
    assign bus.CLR_EN     = clr_en;
    assign bus.OCC        = occ;
    assign bus.ERR        = err;
endmodule
